icap_bitstream_feeder: RTL and testbench

Upstream feeder for the ICAP state machine: accepts 32-bit partial-bitstream words over a valid/ready stream, optionally bit-swaps each byte, and serializes each word into BUS_WIDTH-wide lanes on `icap_in`/`write_req`. It throttles on the ICAP stage's `busy`. It also tracks the configuration sync word, counts accepted words, and flags streams that end before sync. It sits between the bitstream source (DMA/FIFO) and the ICAP state machine.

---
 rtl/icap_bitstream_feeder.sv | 161 ++++++++++++++++
 tb/tb_icap_bitstream_feeder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/icap_bitstream_feeder.sv
// Stream-to-ICAP feeder: captures 32-bit words, serializes them MSB-first into BUS_WIDTH lanes.
// Optional per-byte bit reversal is compiled in with ICAP_FEEDER_BITSWAP_EN.
module icap_bitstream_feeder #(
    parameter int unsigned BUS_WIDTH   = 8,
    parameter int unsigned COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [31:0]            s_data,
    input  logic                   s_valid,
    input  logic                   s_last,
    output logic                   s_ready,
    input  logic                   icap_busy,
    output logic [BUS_WIDTH-1:0]   icap_in,
    output logic                   write_req,
    output logic                   done,
    output logic                   synced,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] word_cnt
);

    localparam int unsigned LANES     = 32 / BUS_WIDTH;
    localparam int unsigned KW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [31:0] SYNC_WORD = 32'hAA995566;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [31:0]            word_q, word_d;
    logic                   last_q, last_d;
    logic                   done_q, done_d;
    logic                   synced_q, synced_d;
    logic                   error_q, error_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

    logic final_lane;
    logic accept;
    logic is_sync;

    // Byte-wise bit reversal (ICAP bit ordering) or pass-through.
    function automatic logic [31:0] prep_word(input logic [31:0] w);
        logic [31:0] r;
`ifdef ICAP_FEEDER_BITSWAP_EN
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[8*b + i] = w[8*b + 7 - i];
            end
        end
`else
        r = w;
`endif
        return r;
    endfunction

    assign final_lane = (k_q == KW'(LANES - 1));
    assign write_req  = (state_q == SEND) && !icap_busy && !abort;
    assign s_ready    = !abort && ((state_q == ARMED) ||
                        ((state_q == SEND) && final_lane && !icap_busy && !last_q));
    assign accept     = s_valid && s_ready;
    assign is_sync    = (s_data == SYNC_WORD);

    // Lane 0 always sits in the top bits of the shifting word register.
    assign icap_in  = word_q[31 -: BUS_WIDTH];
    assign done     = done_q;
    assign synced   = synced_q;
    assign error    = error_q;
    assign word_cnt = cnt_q;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        word_d   = word_q;
        last_d   = last_q;
        synced_d = synced_q;
        error_d  = error_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d  = ARMED;
                    cnt_d    = '0;
                    synced_d = 1'b0;
                    error_d  = 1'b0;
                end
            end
            ARMED: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (write_req) begin
                    if (!final_lane) begin
                        k_d    = k_q + KW'(1);
                        word_d = word_q << BUS_WIDTH;
                    end else if (last_q) begin
                        state_d = DONE;
                    end else if (!accept) begin
                        state_d = ARMED;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Word load and per-word bookkeeping share one accept condition.
        if (accept) begin
            word_d   = prep_word(s_data);
            last_d   = s_last;
            k_d      = '0;
            cnt_d    = (&cnt_q) ? cnt_q : cnt_q + COUNT_WIDTH'(1);
            synced_d = synced_q || is_sync;
            if (s_last && !(synced_q || is_sync)) begin
                error_d = 1'b1;
            end
        end

        if (abort) begin
            state_d = IDLE;
        end

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            k_q      <= '0;
            word_q   <= '0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            synced_q <= 1'b0;
            error_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            word_q   <= word_d;
            last_q   <= last_d;
            done_q   <= done_d;
            synced_q <= synced_d;
            error_q  <= error_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_icap_bitstream_feeder.sv
// Directed bench for icap_bitstream_feeder: 8-bit lane instance plus a 32-bit lane instance.
module tb_icap_bitstream_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, s_valid, s_last, icap_busy;
    logic [31:0] s_data;
    logic        s_ready, write_req, done, synced, error;
    logic [7:0]  icap_in;
    logic [23:0] word_cnt;

    logic        start32, s_valid32, s_last32;
    logic [31:0] s_data32;
    logic        s_ready32, write_req32, done32, synced32, error32;
    logic [31:0] icap_in32;
    logic [23:0] word_cnt32;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] words [3];

    always #5 clk = ~clk;

    icap_bitstream_feeder #(.BUS_WIDTH(8), .COUNT_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .icap_busy(icap_busy), .icap_in(icap_in), .write_req(write_req),
        .done(done), .synced(synced), .error(error), .word_cnt(word_cnt)
    );

    icap_bitstream_feeder #(.BUS_WIDTH(32), .COUNT_WIDTH(24)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .abort(1'b0),
        .s_data(s_data32), .s_valid(s_valid32), .s_last(s_last32), .s_ready(s_ready32),
        .icap_busy(1'b0), .icap_in(icap_in32), .write_req(write_req32),
        .done(done32), .synced(synced32), .error(error32), .word_cnt(word_cnt32)
    );

    // Reference byte ordering for the current build.
    function automatic logic [31:0] ref_swap(input logic [31:0] w);
        logic [31:0] r;
        r = w;
`ifdef ICAP_FEEDER_BITSWAP_EN
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8; i++)
                r[8*b + i] = w[8*b + 7 - i];
`endif
        return r;
    endfunction

    function automatic logic [7:0] ref_lane(input logic [31:0] w, input int k);
        logic [31:0] s;
        s = ref_swap(w);
        return s[31 - 8*k -: 8];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_last = 1'b0;
        s_data = '0; icap_busy = 1'b0;
        start32 = 1'b0; s_valid32 = 1'b0; s_last32 = 1'b0; s_data32 = '0;
        tick(); tick();
        chk("rst_write_req", 32'(write_req), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_synced", 32'(synced), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_icap_in", 32'(icap_in), 32'd0);
        rst = 1'b0;
        tick();

        // Single sync word with s_last
        start = 1'b1; tick(); start = 1'b0;
        #1 chk("armed_s_ready", 32'(s_ready), 32'd1);
        s_valid = 1'b1; s_data = 32'hAA995566; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("single_wr", 32'(write_req), 32'd1);
            chk("single_lane", 32'(icap_in), 32'(ref_lane(32'hAA995566, k)));
            chk("single_s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        #1;
        chk("single_done", 32'(done), 32'd1);
        chk("single_done_wr", 32'(write_req), 32'd0);
        chk("single_synced", 32'(synced), 32'd1);
        chk("single_cnt", 32'(word_cnt), 32'd1);
        chk("single_error", 32'(error), 32'd0);
        tick();
        chk("single_done_off", 32'(done), 32'd0);

        // Back-to-back, three words, s_valid held high
        words[0] = 32'h01234567; words[1] = 32'h89ABCDEF; words[2] = 32'hAA995566;
        start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = words[0]; s_last = 1'b0;
        #1 chk("b2b_armed_ready", 32'(s_ready), 32'd1);
        tick();
        s_data = words[1];
        for (int wi = 0; wi < 3; wi++) begin
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("b2b_wr", 32'(write_req), 32'd1);
                chk("b2b_lane", 32'(icap_in), 32'(ref_lane(words[wi], k)));
                chk("b2b_s_ready", 32'(s_ready), (k == 3 && wi < 2) ? 32'd1 : 32'd0);
                tick();
                if (k == 3 && wi == 0) begin
                    s_data = words[2]; s_last = 1'b1;
                end
                if (k == 3 && wi == 1) begin
                    s_valid = 1'b0; s_last = 1'b0;
                end
            end
        end
        #1;
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_cnt", 32'(word_cnt), 32'd3);
        chk("b2b_synced", 32'(synced), 32'd1);
        chk("b2b_error", 32'(error), 32'd0);
        tick();

        // Stall for two cycles on lane 2
        start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'hAA995566; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("stall_pre_wr", 32'(write_req), 32'd1);
            chk("stall_pre_lane", 32'(icap_in), 32'(ref_lane(32'hAA995566, k)));
            tick();
        end
        icap_busy = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("stall_wr", 32'(write_req), 32'd0);
            chk("stall_hold", 32'(icap_in), 32'(ref_lane(32'hAA995566, 2)));
            tick();
        end
        icap_busy = 1'b0;
        for (int k = 2; k < 4; k++) begin
            #1;
            chk("stall_post_wr", 32'(write_req), 32'd1);
            chk("stall_post_lane", 32'(icap_in), 32'(ref_lane(32'hAA995566, k)));
            tick();
        end
        #1 chk("stall_done", 32'(done), 32'd1);
        tick();

        // Stream ends without a sync word
        start = 1'b1; tick(); start = 1'b0;
        s_valid = 1'b1; s_data = 32'h12345678; s_last = 1'b1;
        tick();
        s_valid = 1'b0; s_last = 1'b0;
        #1 chk("nosync_error_early", 32'(error), 32'd1);
        tick(); tick(); tick(); tick();
        #1;
        chk("nosync_done", 32'(done), 32'd1);
        chk("nosync_error", 32'(error), 32'd1);
        chk("nosync_synced", 32'(synced), 32'd0);
        tick();

        // Abort during lane 1 of word 2
        start = 1'b1; tick(); start = 1'b0;
        #1 chk("abort_start_clr_err", 32'(error), 32'd0);
        s_valid = 1'b1; s_data = 32'h01020304; s_last = 1'b0;
        tick();
        s_data = 32'h05060708;
        tick(); tick(); tick();
        #1 chk("abort_final_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        tick();
        abort = 1'b1;
        #1;
        chk("abort_wr", 32'(write_req), 32'd0);
        chk("abort_s_ready", 32'(s_ready), 32'd0);
        tick();
        start = 1'b1;
        #1;
        chk("abort_idle_ready", 32'(s_ready), 32'd0);
        chk("abort_idle_wr", 32'(write_req), 32'd0);
        chk("abort_cnt_kept", 32'(word_cnt), 32'd2);
        tick();
        start = 1'b0; abort = 1'b0;
        #1;
        chk("start_abort_idle", 32'(s_ready), 32'd0);
        chk("start_abort_cnt", 32'(word_cnt), 32'd2);
        start = 1'b1; tick(); start = 1'b0;
        #1;
        chk("restart_cnt_clr", 32'(word_cnt), 32'd0);
        chk("restart_ready", 32'(s_ready), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        #1 chk("armed_abort_idle", 32'(s_ready), 32'd0);

        // 32-bit lane instance: one lane per word
        start32 = 1'b1; tick(); start32 = 1'b0;
        s_valid32 = 1'b1; s_data32 = 32'hAA995566; s_last32 = 1'b1;
        #1 chk("w32_ready", 32'(s_ready32), 32'd1);
        tick();
        s_valid32 = 1'b0; s_last32 = 1'b0;
        #1;
        chk("w32_wr", 32'(write_req32), 32'd1);
        chk("w32_data", icap_in32, ref_swap(32'hAA995566));
        tick();
        #1;
        chk("w32_done", 32'(done32), 32'd1);
        chk("w32_wr_off", 32'(write_req32), 32'd0);
        chk("w32_synced", 32'(synced32), 32'd1);
        chk("w32_cnt", 32'(word_cnt32), 32'd1);
        chk("w32_error", 32'(error32), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
